// File: rtl/transposed_fir_accum_chain.sv
// ============================================================================
// Module      : transposed_fir_accum_chain
// Description : Transposed-form FIR adder/delay chain fed with per-tap
//               products. Produces one rounded, saturated sample per accepted
//               beat behind a valid/ready output register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module transposed_fir_accum_chain #(
    parameter int NUM_TAPS = 8,
    parameter int PROD_W   = 25,
    parameter int ACC_W    = PROD_W + 3,
    parameter int OUT_W    = 16,
    parameter int SHIFT    = 8
) (
    input  logic                       ap_clk,
    input  logic                       ap_rst,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [NUM_TAPS*PROD_W-1:0] s_prod,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [OUT_W-1:0]           m_data,
    output logic                       m_sat
);

    // Rounding and clamping are evaluated one bit wider than the accumulator
    // so the half-LSB add can never wrap.
    localparam logic signed [ACC_W:0] c_RND =
        $signed({{ACC_W{1'b0}}, 1'b1} << (SHIFT - 1));
    localparam logic signed [ACC_W:0] c_SAT_MAX =
        $signed({{(ACC_W + 2 - OUT_W){1'b0}}, {(OUT_W - 1){1'b1}}});
    localparam logic signed [ACC_W:0] c_SAT_MIN =
        $signed({{(ACC_W + 2 - OUT_W){1'b1}}, {(OUT_W - 1){1'b0}}});
    localparam logic [OUT_W-1:0] c_OUT_MAX = {1'b0, {(OUT_W - 1){1'b1}}};
    localparam logic [OUT_W-1:0] c_OUT_MIN = {1'b1, {(OUT_W - 1){1'b0}}};

    logic signed [ACC_W-1:0] w_p [NUM_TAPS];
    logic signed [ACC_W-1:0] r_z [NUM_TAPS-1];

    logic                    w_accept;
    logic signed [ACC_W-1:0] w_acc;
    logic signed [ACC_W:0]   w_acc_ext;
    logic signed [ACC_W:0]   w_rnd;
    logic signed [ACC_W:0]   w_r;
    logic [OUT_W-1:0]        w_data;
    logic                    w_sat;

    logic                    r_m_valid;
    logic [OUT_W-1:0]        r_m_data;
    logic                    r_m_sat;

    assign s_ready  = !r_m_valid || m_ready;
    assign w_accept = s_valid && s_ready;

    generate
        for (genvar k = 0; k < NUM_TAPS; k++) begin : g_sext
            assign w_p[k] = $signed({{(ACC_W - PROD_W){s_prod[k*PROD_W + PROD_W - 1]}},
                                     s_prod[k*PROD_W +: PROD_W]});
        end
    endgenerate

    // Partial sums advance only on an accepted beat; the chain is indexed by
    // sample, so idle or stalled cycles leave it untouched.
    generate
        for (genvar k = 0; k < NUM_TAPS - 2; k++) begin : g_chain
            always_ff @(posedge ap_clk) begin
                if (ap_rst) begin
                    r_z[k] <= '0;
                end else if (w_accept) begin
                    r_z[k] <= w_p[k+1] + r_z[k+1];
                end
            end
        end
    endgenerate

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_z[NUM_TAPS-2] <= '0;
        end else if (w_accept) begin
            r_z[NUM_TAPS-2] <= w_p[NUM_TAPS-1];
        end
    end

    assign w_acc     = w_p[0] + r_z[0];
    assign w_acc_ext = {w_acc[ACC_W-1], w_acc};
    assign w_rnd     = w_acc_ext + c_RND;
    assign w_r       = w_rnd >>> SHIFT;

    always_comb begin
        w_data = w_r[OUT_W-1:0];
        w_sat  = 1'b0;
        if (w_r > c_SAT_MAX) begin
            w_data = c_OUT_MAX;
            w_sat  = 1'b1;
        end else if (w_r < c_SAT_MIN) begin
            w_data = c_OUT_MIN;
            w_sat  = 1'b1;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_m_sat   <= 1'b0;
        end else if (w_accept) begin
            r_m_valid <= 1'b1;
            r_m_data  <= w_data;
            r_m_sat   <= w_sat;
        end else if (m_ready) begin
            r_m_valid <= 1'b0;
        end
    end

    assign m_valid = r_m_valid;
    assign m_data  = r_m_data;
    assign m_sat   = r_m_sat;

endmodule

`default_nettype wire

// File: tb/tb_transposed_fir_accum_chain.sv
// ============================================================================
// Module      : tb_transposed_fir_accum_chain
// Description : Directed bench for transposed_fir_accum_chain.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_transposed_fir_accum_chain;

    localparam int NUM_TAPS = 8;
    localparam int PROD_W   = 25;
    localparam int OUT_W    = 16;

    logic                       ap_clk;
    logic                       ap_rst;
    logic                       s_valid;
    logic                       s_ready;
    logic [NUM_TAPS*PROD_W-1:0] s_prod;
    logic                       m_valid;
    logic                       m_ready;
    logic [OUT_W-1:0]           m_data;
    logic                       m_sat;

    int pv [NUM_TAPS];
    int n_checks;
    int n_fail;

    transposed_fir_accum_chain #(
        .NUM_TAPS(NUM_TAPS),
        .PROD_W  (PROD_W),
        .ACC_W   (PROD_W + 3),
        .OUT_W   (OUT_W),
        .SHIFT   (8)
    ) u_dut (
        .ap_clk (ap_clk),
        .ap_rst (ap_rst),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .s_prod (s_prod),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_data (m_data),
        .m_sat  (m_sat)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic pack();
        for (int k = 0; k < NUM_TAPS; k++) begin
            s_prod[k*PROD_W +: PROD_W] = pv[k][PROD_W-1:0];
        end
    endtask

    task automatic set_all(input int v);
        for (int k = 0; k < NUM_TAPS; k++) pv[k] = v;
        pack();
    endtask

    task automatic do_reset();
        ap_rst  = 1'b1;
        s_valid = 1'b0;
        m_ready = 1'b1;
        set_all(0);
        cyc();
        cyc();
        ap_rst = 1'b0;
    endtask

    task automatic beat();
        pack();
        s_valid = 1'b1;
        cyc();
    endtask

    task automatic check_out(input string tag, input int exp_data, input int exp_sat);
        check({tag, "_valid"}, int'(m_valid), 1);
        check({tag, "_data"}, int'($signed(m_data)), exp_data);
        check({tag, "_sat"}, int'(m_sat), exp_sat);
    endtask

    int sat_exp_d [16];
    int sat_exp_s [16];
    int rnd_in    [4];
    int rnd_exp   [4];
    int tp_count;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        ap_rst   = 1'b1;
        s_valid  = 1'b0;
        m_ready  = 1'b0;
        s_prod   = '0;

        sat_exp_d = '{32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767,
                      32767, 32767, 32767, 0, -32768, -32768, -32768, -32768};
        sat_exp_s = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 1, 1, 1, 1};
        rnd_in    = '{128, 127, -128, -129};
        rnd_exp   = '{1, 0, 0, -1};

        // Reset state
        do_reset();
        check("rst_valid", int'(m_valid), 0);
        check("rst_data", int'(m_data), 0);
        check("rst_sat", int'(m_sat), 0);
        check("rst_sready", int'(s_ready), 1);

        // Impulse: one tap-weighted beat then zeros
        for (int k = 0; k < NUM_TAPS; k++) pv[k] = (k + 1) * 256;
        beat();
        check_out("imp0", 1, 0);
        set_all(0);
        for (int i = 1; i <= 8; i++) begin
            beat();
            check_out($sformatf("imp%0d", i), (i < 8) ? i + 1 : 0, 0);
        end

        // Backpressure mid-stream
        do_reset();
        for (int k = 0; k < NUM_TAPS; k++) pv[k] = (k + 1) * 256;
        beat();
        check_out("bp0", 1, 0);
        set_all(0);
        beat();
        check_out("bp1", 2, 0);
        set_all(4096);
        for (int i = 0; i < 3; i++) begin
            m_ready = 1'b0;
            s_valid = 1'b1;
            #1;
            check($sformatf("bp_stall_sready%0d", i), int'(s_ready), 0);
            cyc();
            check_out($sformatf("bp_hold%0d", i), 2, 0);
        end
        m_ready = 1'b1;
        set_all(0);
        for (int i = 2; i <= 8; i++) begin
            beat();
            check_out($sformatf("bp%0d", i), (i < 8) ? i + 1 : 0, 0);
        end

        // Saturation, both rails
        do_reset();
        for (int i = 0; i < 16; i++) begin
            set_all((i < 8) ? 16777215 : -16777216);
            beat();
            check_out($sformatf("sat%0d", i), sat_exp_d[i], sat_exp_s[i]);
        end

        // Rounding on tap 0 only
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_all(0);
            pv[0] = rnd_in[i];
            beat();
            check_out($sformatf("rnd%0d", i), rnd_exp[i], 0);
        end

        // Reset mid-stream
        do_reset();
        for (int k = 0; k < NUM_TAPS; k++) pv[k] = (k + 1) * 256;
        beat();
        set_all(0);
        beat();
        check_out("mrst_pre", 2, 0);
        ap_rst  = 1'b1;
        s_valid = 1'b0;
        cyc();
        ap_rst = 1'b0;
        check("mrst_valid", int'(m_valid), 0);
        check("mrst_data", int'(m_data), 0);
        for (int i = 0; i < 3; i++) begin
            beat();
            check_out($sformatf("mrst_post%0d", i), 0, 0);
        end

        // Full throughput
        do_reset();
        tp_count = 0;
        for (int i = 0; i < 20; i++) begin
            set_all(0);
            pv[0] = i * 256;
            pack();
            s_valid = 1'b1;
            m_ready = 1'b1;
            #1;
            check($sformatf("tp_sready%0d", i), int'(s_ready), 1);
            cyc();
            if (m_valid) tp_count++;
            check($sformatf("tp_data%0d", i), int'($signed(m_data)), i);
        end
        s_valid = 1'b0;
        cyc();
        check("tp_count", tp_count, 20);
        check("tp_drain_valid", int'(m_valid), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
